// File: rtl/cache_pkg.sv
// cache_pkg: shared cache types and constants.
// Provides the arbiter state encoding and the write-mode constants used by
// the cache blocks. No ports.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} arb_state_t;
  localparam int WRITE_AROUND  = 0;
  localparam int WRITE_THROUGH = 1;
  localparam int WRITE_BACK    = 2;
endpackage

// File: rtl/cache_arb_timer.sv
// cache_arb_timer: watchdog counter for a granted lower-level transaction.
// Ports: clock, reset (sync, active-high); clear zeroes the count; run counts
// one per cycle; expired is high while running with count == TIMEOUT-1
// (never when TIMEOUT == 0).
module cache_arb_timer
  import cache_pkg::*;
#(
  parameter int TIMEOUT = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0] r_cnt;
  assign expired = (TIMEOUT != 0) && run && (r_cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clock) begin
    if (reset || clear) r_cnt <= '0;
    else if (run && !expired) r_cnt <= r_cnt + CW'(1);
  end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: two-port round-robin arbiter sharing one lower memory level.
// Ports: clock/reset (sync, active-high); per requester k: addrInk, dataUpInk,
// enableInk, writeInk in and dataUpOutk, fetchCompletek, writeCompleteOutk out;
// to the lower level: addrOut, dataDownOut, enableOut, writeOut out and
// dataDownIn, fetchReceive, writeCompleteIn in; timeoutOut pulses on watchdog
// expiry. All outputs are registered.
module cache_arbiter
  import cache_pkg::*;
#(
  parameter int ADDR_LENGTH = 10,
  parameter int DATA_WIDTH  = 64,
  parameter int TIMEOUT     = 256
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_LENGTH-1:0] addrIn0,
  input  logic [ADDR_LENGTH-1:0] addrIn1,
  input  logic [DATA_WIDTH-1:0]  dataUpIn0,
  input  logic [DATA_WIDTH-1:0]  dataUpIn1,
  input  logic                   enableIn0,
  input  logic                   enableIn1,
  input  logic                   writeIn0,
  input  logic                   writeIn1,
  output logic [DATA_WIDTH-1:0]  dataUpOut0,
  output logic [DATA_WIDTH-1:0]  dataUpOut1,
  output logic                   fetchComplete0,
  output logic                   fetchComplete1,
  output logic                   writeCompleteOut0,
  output logic                   writeCompleteOut1,
  output logic [ADDR_LENGTH-1:0] addrOut,
  output logic [DATA_WIDTH-1:0]  dataDownOut,
  output logic                   enableOut,
  output logic                   writeOut,
  input  logic [DATA_WIDTH-1:0]  dataDownIn,
  input  logic                   fetchReceive,
  input  logic                   writeCompleteIn,
  output logic                   timeoutOut
);
  arb_state_t r_state, w_next;
  logic r_prio, r_win;
  logic [1:0] r_fc, r_wc;
  logic [DATA_WIDTH-1:0] r_dup [2];
  logic w_req, w_pick, w_en_win, w_cmp, w_exp;
  assign w_req    = enableIn0 | enableIn1;
  assign w_pick   = (enableIn0 & enableIn1) ? r_prio : enableIn1;
  assign w_en_win = r_win ? enableIn1 : enableIn0;
  assign w_cmp    = fetchReceive | writeCompleteIn;
  assign dataUpOut0        = r_dup[0];
  assign dataUpOut1        = r_dup[1];
  assign fetchComplete0    = r_fc[0];
  assign fetchComplete1    = r_fc[1];
  assign writeCompleteOut0 = r_wc[0];
  assign writeCompleteOut1 = r_wc[1];
  cache_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (r_state != BUSY),
    .run    (r_state == BUSY),
    .expired(w_exp)
  );
  // A lower-level completion outranks both expiry and an abort in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_req ? BUSY : IDLE;
      BUSY:    w_next = (w_cmp || w_exp) ? DONE : (w_en_win ? BUSY : RELEASE);
      DONE:    w_next = w_en_win ? DONE : RELEASE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_prio      <= 1'b0;
      r_win       <= 1'b0;
      r_fc        <= '0;
      r_wc        <= '0;
      r_dup[0]    <= '0;
      r_dup[1]    <= '0;
      addrOut     <= '0;
      dataDownOut <= '0;
      enableOut   <= 1'b0;
      writeOut    <= 1'b0;
      timeoutOut  <= 1'b0;
    end else begin
      r_state    <= w_next;
      timeoutOut <= 1'b0;
      case (r_state)
        IDLE: if (w_req) begin
          r_win       <= w_pick;
          addrOut     <= w_pick ? addrIn1 : addrIn0;
          dataDownOut <= w_pick ? dataUpIn1 : dataUpIn0;
          writeOut    <= w_pick ? writeIn1 : writeIn0;
          enableOut   <= 1'b1;
        end
        BUSY: if (w_cmp) begin
          enableOut <= 1'b0;
          if (fetchReceive) begin
            r_dup[r_win] <= dataDownIn;
            r_fc[r_win]  <= 1'b1;
          end
          if (writeCompleteIn) r_wc[r_win] <= 1'b1;
        end else if (w_exp) begin
          enableOut    <= 1'b0;
          timeoutOut   <= 1'b1;
          r_dup[r_win] <= '0;
          if (writeOut) r_wc[r_win] <= 1'b1;
          else r_fc[r_win] <= 1'b1;
        end else if (!w_en_win) enableOut <= 1'b0;
        DONE: if (!w_en_win) begin
          r_fc <= '0;
          r_wc <= '0;
        end
        default: r_prio <= ~r_win;
      endcase
    end
  end
endmodule
